// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the load/store bus-master slice: the memory
// operation encoding, access-size classification and the base byteenable
// patterns that the lane aligner shifts into position.
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  // Lane-0 byteenable patterns; shifted left by the byte offset.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_load(input mem_op_t op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  function automatic mem_size_t size_of(input mem_op_t op);
    mem_size_t sz;
    case (op)
      LB, LBU, SB: sz = SZ_BYTE;
      LH, LHU, SH: sz = SZ_HALF;
      default:     sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Purely combinational little-endian lane steering for one access.
// Ports:
//   op          in  mem_op_t  load/store operation
//   addr_lo     in  [1:0]     byte offset within the word
//   wdata       in  [31:0]    right-justified store data
//   rdata       in  [31:0]    raw word read from the bus
//   byteenable  out [3:0]     lane enables for the access
//   wdata_lanes out [31:0]    store data shifted into its lanes, other lanes 0
//   rdata_ext   out [31:0]    selected lanes, sign/zero extended per op
//   misaligned  out           access crosses its natural alignment
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [4:0]  shamt;
  logic [31:0] rdata_sh;

  // Byte offset in bits. For an aligned halfword addr_lo[0] is 0, so the
  // same shift serves bytes and halves.
  assign shamt    = {addr_lo, 3'b000};
  assign rdata_sh = rdata >> shamt;

  always_comb begin
    byteenable  = BE_WORD;
    wdata_lanes = wdata;
    rdata_ext   = rdata;
    misaligned  = 1'b0;
    case (size_of(op))
      SZ_BYTE: begin
        byteenable  = BE_BYTE << addr_lo;
        wdata_lanes = {24'b0, wdata[7:0]} << shamt;
        rdata_ext   = (op == LB) ? {{24{rdata_sh[7]}}, rdata_sh[7:0]}
                                 : {24'b0, rdata_sh[7:0]};
      end
      SZ_HALF: begin
        misaligned  = addr_lo[0];
        byteenable  = BE_HALF << addr_lo;
        wdata_lanes = {16'b0, wdata[15:0]} << shamt;
        rdata_ext   = (op == LH) ? {{16{rdata_sh[15]}}, rdata_sh[15:0]}
                                 : {16'b0, rdata_sh[15:0]};
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master
// Single-outstanding bus master between the load/store unit and an
// Avalon-style data memory. One request is accepted in IDLE, the bus
// strobe is held through waitrequest in BUS, and a one-cycle response
// is issued from RESP. Misaligned requests skip the bus entirely.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_op/addr/wdata       request operation, byte address, store data
//   resp_valid/err/rdata    one-cycle response with extended load data
//   address/read/write      bus command (word-aligned address)
//   writedata/byteenable    lane-steered store data and lane enables
//   readdata/waitrequest    slave return data and stall
module mem_bus_master
  import mem_pkg::*;
#(
  parameter int ADDR_W            = 32,
  parameter int RESET_ON_MISALIGN = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_op_t           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata,
  input  logic              waitrequest
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  mem_op_t    op_q;
  logic [1:0] addr_lo_q;

  mem_op_t     align_op;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;
  logic        align_misaligned;

  // The reserved misalign option has no alternative behaviour; misaligned
  // requests never reach the bus whatever its value.
  logic unused_cfg;
  assign unused_cfg = (RESET_ON_MISALIGN != 0);

  // One aligner serves both phases: in IDLE it looks at the incoming
  // request, afterwards at the latched request for load extraction.
  assign align_op      = (state == IDLE) ? req_op        : op_q;
  assign align_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;

  mem_lane_align u_align (
    .op          (align_op),
    .addr_lo     (align_addr_lo),
    .wdata       (req_wdata),
    .rdata       (readdata),
    .byteenable  (align_be),
    .wdata_lanes (align_wdata),
    .rdata_ext   (align_rdata),
    .misaligned  (align_misaligned)
  );

  // Control FSM with every output registered. req_ready comes up one cycle
  // after reset releases and again on leaving RESP, which limits
  // throughput to one access per three cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= LB;
      addr_lo_q  <= 2'b00;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            addr_lo_q <= req_addr[1:0];
            req_ready <= 1'b0;
            if (align_misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state      <= BUS;
              address    <= {req_addr[ADDR_W-1:2], 2'b00};
              byteenable <= align_be;
              read       <= is_load(req_op);
              write      <= !is_load(req_op);
              writedata  <= is_load(req_op) ? 32'h0 : align_wdata;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        BUS: begin
          if (!waitrequest) begin
            state      <= RESP;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            writedata  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= is_load(op_q) ? align_rdata : 32'h0;
          end
        end

        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus-master stage between the CPU's load/store unit and the Avalon-style data memory. Accepts one load/store request at a time, converts the byte address and access size into a word-aligned bus address, byteenable and lane-shifted writedata. Holds `read`/`write` stable until the slave drops `waitrequest`. Returns sign- or zero-extended load data with a one-cycle response strobe.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on both sides
- RESET_ON_MISALIGN, 0, if 1 a misaligned request is still reported as an error but never reaches the bus (always the case); reserved, must stay 0

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on `clk` rising edge
- req_valid  in  1  CPU request present
- req_ready  out  1  high only in IDLE; request accepted on edge where `req_valid && req_ready`
- req_op  in  3  mem_op_t: LB, LBU, LH, LHU, LW, SB, SH, SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse, request finished
- resp_err  out  1  valid with resp_valid; misaligned access
- resp_rdata  out  32  extended load data; 0 for stores and errors
- address  out  32  word-aligned bus address ({req_addr[31:2],2'b00})
- read  out  1  bus read strobe
- write  out  1  bus write strobe
- writedata  out  32  lane-shifted store data
- byteenable  out  4  active-high lane enables
- readdata  in  32  slave read data, valid when `read && !waitrequest`
- waitrequest  in  1  slave stall

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: `req_ready=1`. On accept, latch op/addr/wdata. If misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) go to RESP with err=1, no bus cycle. Otherwise drive bus outputs from the next cycle and go to BUS.
- BUS: `read` (loads) or `write` (stores) held high. `address`, `writedata` and `byteenable` are held constant. While `waitrequest=1`, stay in BUS. On an edge with `waitrequest=0`, capture `readdata` (loads), drop strobes and go to RESP.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE.
- Byte lanes (little-endian): byte k=addr[1:0] → byteenable=1<<k, writedata=wdata[7:0]<<8k. Half h=addr[1] → byteenable=4'b0011<<2h, writedata=wdata[15:0]<<16h. Word → 4'b1111.
- Load extract: same lane select. LB/LH sign-extend; LBU/LHU zero-extend; LW pass-through.
- Unused writedata lanes are driven 0. byteenable is 0 whenever read and write are both 0.

## Timing
- Reset values: req_ready=0 during reset cycle, then 1 (IDLE). read=write=0, byteenable=0, address=0, writedata=0, resp_valid=0, resp_err=0, resp_rdata=0.
- Accept at edge N → read/write high in cycle N+1. With zero wait, resp_valid is high in cycle N+2. Each waitrequest cycle adds 1.
- Misaligned: accept at edge N → resp_valid/resp_err in cycle N+1.
- Back-to-back: next request is accepted no earlier than the cycle after resp_valid. Throughput is at most one access per 3 cycles.
- read and write are never high together. Strobes never drop while waitrequest=1.
- Reset mid-BUS: strobes low in the cycle after the reset edge, the transfer is abandoned and no resp_valid is issued. Reset in RESP suppresses that pulse.
- `readdata` is ignored outside BUS with waitrequest=0.

## Structure
- Shared package `mem_pkg`: `mem_op_t` enum; `is_load(op)`, `size_of(op)` helpers; `BE_BYTE/BE_HALF/BE_WORD` constants.
- Sub-module `mem_lane_align` (combinational): op+addr[1:0]+wdata/readdata → byteenable, shifted writedata, extended load data, misalign flag. The FSM lives in the top.

## Test plan
- SW addr 0xBFC00010 data 0xDEADBEEF, waitrequest=0 → cycle N+1: write=1, address=0xBFC00010, byteenable=1111, writedata=0xDEADBEEF. resp_valid at N+2, err=0.
- SB addr 0xBFC00013 data 0x000000A5 → byteenable=1000, writedata=0xA5000000. Then LB same addr with readdata=0xA5000000 → resp_rdata=0xFFFFFFA5. LBU → 0x000000A5.
- LH addr 0x...02 with readdata=0x8001_1234 → byteenable=1100, rdata=0xFFFF8001. LHU addr 0x...00 → rdata=0x00001234.
- LW with waitrequest high 3 cycles → read, address and byteenable stable for 4 cycles, resp_valid at N+5 with captured readdata.
- LW addr 0x...02 → no read/write ever asserted, resp_valid+resp_err at N+1, rdata=0. SH addr 0x...01 behaves the same.
- Reset asserted during BUS with waitrequest=1 → read=0 next cycle, no resp_valid, req_ready=1 afterwards. A new LW then completes normally.
